// File: rtl/gf2_pkg.sv
// Shared types and constants for the GF(2) matrix-vector front end and its multiplier.
package gf2_pkg;

  localparam int GF2_N = 3;

  typedef enum logic [1:0] {
    LOAD_M = 2'd0,
    LOAD_V = 2'd1,
    CALC   = 2'd2,
    SEND   = 2'd3
  } gf2_seq_state_t;

  // 2-bit entries are GF(4) = GF(2)[x]/(x^2+x+1); with bit 1 at 0 this reduces to AND.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] p;
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[1]);
    p[0] = (a[0] & b[0]) ^ (a[1] & b[1]);
    return p;
  endfunction

endpackage

// File: rtl/matrix_vec_mul.sv
// Purely combinational matrix-vector product over 2-bit entries; m_cols[c][r] is row r of column c.
module matrix_vec_mul
  import gf2_pkg::*;
#(
  parameter int n = GF2_N
) (
  input  logic [n-1:0][n-1:0][1:0] m_cols,
  input  logic [n-1:0][1:0]        v,
  output logic [n-1:0][1:0]        u
);

  // Each row accumulates the XOR of its column-scaled products.
  always_comb begin
    u = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        u[r] = u[r] ^ gf4_mul(m_cols[c][r], v[c]);
      end
    end
  end

endmodule

// File: rtl/gf2_matvec_seq.sv
// Stream front end: loads M column by column plus v, runs matrix_vec_mul, returns u on a valid/ready port.
module gf2_matvec_seq
  import gf2_pkg::*;
#(
  parameter int n = GF2_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  input  logic         in_vec_only,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data
);

  localparam int CW = $clog2(n);

  gf2_seq_state_t        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  m_loaded_q, m_loaded_d;
  logic [n-1:0][n-1:0]   col_q, col_d;
  logic [n-1:0]          vec_q, vec_d;
  logic [n-1:0]          out_data_q, out_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic                  in_acc_s;
  logic                  out_acc_s;
  logic [n-1:0][n-1:0][1:0] mat_s;
  logic [n-1:0][1:0]     vec2_s;
  logic [n-1:0][1:0]     prod_s;
  logic [n-1:0]          prod_hi_s;
  logic                  unused_prod_hi_s;

  // Widen the stored 1-bit entries into the multiplier's 2-bit entries.
  always_comb begin
    mat_s     = '0;
    vec2_s    = '0;
    prod_hi_s = '0;
    for (int c = 0; c < n; c++) begin
      vec2_s[c]    = {1'b0, vec_q[c]};
      prod_hi_s[c] = prod_s[c][1];
      for (int r = 0; r < n; r++) begin
        mat_s[c][r] = {1'b0, col_q[c][r]};
      end
    end
  end

  assign unused_prod_hi_s = ^prod_hi_s;

  matrix_vec_mul #(.n(n)) u_mul (
    .m_cols (mat_s),
    .v      (vec2_s),
    .u      (prod_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_loaded_d = m_loaded_q;
    col_d      = col_q;
    vec_d      = vec_q;
    out_data_d = out_data_q;
    in_acc_s   = in_valid && in_ready_q;
    out_acc_s  = out_valid_q && out_ready;
    case (state_q)
      LOAD_M: begin
        if (in_acc_s) begin
          if ((cnt_q == '0) && m_loaded_q && in_vec_only) begin
            vec_d   = in_data;
            state_d = CALC;
          end else begin
            for (int c = 0; c < n; c++) begin
              if (cnt_q == CW'(c)) begin
                col_d[c] = in_data;
              end else begin
                col_d[c] = col_q[c];
              end
            end
            if (cnt_q == CW'(n - 1)) begin
              cnt_d      = '0;
              m_loaded_d = 1'b1;
              state_d    = LOAD_V;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end else begin
          state_d = LOAD_M;
        end
      end
      LOAD_V: begin
        if (in_acc_s) begin
          vec_d   = in_data;
          state_d = CALC;
        end else begin
          state_d = LOAD_V;
        end
      end
      CALC: begin
        for (int r = 0; r < n; r++) begin
          out_data_d[r] = prod_s[r][0];
        end
        state_d = SEND;
      end
      SEND: begin
        if (out_acc_s) begin
          cnt_d   = '0;
          state_d = LOAD_M;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = LOAD_M;
      end
    endcase
    in_ready_d  = (state_d == LOAD_M) || (state_d == LOAD_V);
    out_valid_d = (state_d == SEND);
  end

  // State and output registers; synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_M;
      cnt_q       <= '0;
      m_loaded_q  <= 1'b0;
      col_q       <= '0;
      vec_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_loaded_q  <= m_loaded_d;
      col_q       <= col_d;
      vec_q       <= vec_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf2_matvec_seq.sv
// Directed self-checking bench for gf2_matvec_seq at n=3 with hand-computed products.
module tb_gf2_matvec_seq;

  localparam int N = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_vec_only;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  int checks;
  int errors;

  gf2_matvec_seq #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_vec_only (in_vec_only),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  // Present one beat at a negedge, wait for acceptance, return at the following negedge.
  task automatic send_beat(input logic [N-1:0] d, input logic vo, input int bubbles);
    int t;
    t = 0;
    in_valid    = 1'b1;
    in_data     = d;
    in_vec_only = vo;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    in_vec_only = 1'b0;
    for (int b = 0; b < bubbles; b++) @(negedge clk);
  endtask

  task automatic get_result(input string tag, input logic [N-1:0] exp);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq(tag, {29'd0, out_data}, {29'd0, exp});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic load_full(input logic [N-1:0] c0, input logic [N-1:0] c1,
                           input logic [N-1:0] c2, input logic [N-1:0] v, input int bubbles);
    send_beat(c0, 1'b0, bubbles);
    send_beat(c1, 1'b0, bubbles);
    send_beat(c2, 1'b0, bubbles);
    send_beat(v, 1'b0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_vec_only = 1'b0;
    out_ready = 1'b0;

    do_reset();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {29'd0, out_data}, 32'd0);

    // Flagged first beat after reset must become column 0.
    send_beat(3'b001, 1'b1, 0);
    send_beat(3'b010, 1'b0, 0);
    send_beat(3'b100, 1'b0, 0);
    send_beat(3'b110, 1'b0, 0);
    get_result("flag_after_reset", 3'b110);

    // Identity with explicit latency check.
    load_full(3'b001, 3'b010, 3'b100, 3'b101, 0);
    check_eq("ident_calc_not_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ident_calc_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_eq("ident_latency_valid", {31'd0, out_valid}, 32'd1);
    get_result("identity", 3'b101);

    load_full(3'b011, 3'b110, 3'b100, 3'b011, 0);
    get_result("general_v011", 3'b101);
    load_full(3'b011, 3'b110, 3'b100, 3'b111, 0);
    get_result("general_v111", 3'b001);

    // Vector-only reuse of the stored matrix.
    send_beat(3'b100, 1'b1, 0);
    check_eq("vo_calc_not_valid", {31'd0, out_valid}, 32'd0);
    get_result("vo_v100", 3'b100);
    send_beat(3'b001, 1'b1, 0);
    get_result("vo_col0_kept", 3'b011);
    send_beat(3'b010, 1'b1, 0);
    get_result("vo_col1_kept", 3'b110);

    // Backpressure on the output.
    send_beat(3'b111, 1'b1, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_hold", {29'd0, out_data}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    get_result("bp_release", 3'b001);

    // Input bubbles during the load.
    load_full(3'b011, 3'b110, 3'b100, 3'b011, 1);
    get_result("bubbles", 3'b101);

    // Reset mid-load discards the partial matrix and m_loaded.
    send_beat(3'b011, 1'b0, 0);
    send_beat(3'b110, 1'b0, 0);
    do_reset();
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_out_data", {29'd0, out_data}, 32'd0);
    send_beat(3'b111, 1'b1, 0);
    check_eq("midrst_flag_is_col", {31'd0, in_ready}, 32'd1);
    send_beat(3'b010, 1'b0, 0);
    send_beat(3'b001, 1'b0, 0);
    send_beat(3'b101, 1'b0, 0);
    get_result("midrst_reload", 3'b110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
